// File: rtl/fetch_pkg.sv
// Shared types and helpers for the branch-predicting fetch unit.
package fetch_pkg;

  typedef logic [1:0] ctr_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic ctr_t ctr_inc(ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic ctr_t ctr_dec(ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_bimodal.sv
// Direct-mapped BTB with 2-bit bimodal counters: combinational lookup, registered update.
module btb_bimodal
  import fetch_pkg::*;
#(
  parameter int   BTB_ENTRIES = 256,
  parameter ctr_t CTR_INIT    = 2'b10,
  localparam int  IDXW        = $clog2(BTB_ENTRIES)
) (
  input  logic            i_clk,
  input  logic            clr_en,
  input  logic [IDXW-1:0] clr_idx,
  input  logic [31:0]     lookup_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  input  logic            upd_en,
  input  logic [31:0]     upd_pc,
  input  logic [31:0]     upd_target,
  input  logic            upd_taken
);

  localparam int TAGW = 32 - IDXW - 2;

  logic            valid_q [BTB_ENTRIES];
  logic [TAGW-1:0] tag_q   [BTB_ENTRIES];
  logic [31:0]     tgt_q   [BTB_ENTRIES];
  ctr_t            ctr_q   [BTB_ENTRIES];

  logic [IDXW-1:0] lk_idx, up_idx;
  logic [TAGW-1:0] lk_tag, up_tag;
  logic            lk_hit, up_hit;
  logic            unused_lo;

  assign unused_lo = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx      = lookup_pc[IDXW+1:2];
  assign lk_tag      = lookup_pc[31:IDXW+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target = tgt_q[lk_idx];

  assign up_idx = upd_pc[IDXW+1:2];
  assign up_tag = upd_pc[31:IDXW+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Contents are not reset: the INIT sweep invalidates every entry instead.
  // Writes land at the edge, so a same-cycle lookup sees the old contents.
  always_ff @(posedge i_clk) begin
    if (clr_en) begin
      valid_q[clr_idx] <= 1'b0;
    end else if (upd_en) begin
      if (upd_taken) begin
        if (up_hit) begin
          ctr_q[up_idx] <= ctr_inc(ctr_q[up_idx]);
          tgt_q[up_idx] <= upd_target;
        end else begin
          valid_q[up_idx] <= 1'b1;
          tag_q[up_idx]   <= up_tag;
          tgt_q[up_idx]   <= upd_target;
          ctr_q[up_idx]   <= CTR_INIT;
        end
      end else if (up_hit) begin
        ctr_q[up_idx] <= ctr_dec(ctr_q[up_idx]);
      end
    end
  end

endmodule

// File: rtl/fetch_unit_bp.sv
// Instruction fetch stage: sweeps the BTB clear after reset, then fetches with BTB-predicted next PC.
module fetch_unit_bp
  import fetch_pkg::*;
#(
  parameter int          BTB_ENTRIES = 256,
  parameter logic [31:0] RESET_PC    = 32'h100,
  parameter logic [1:0]  CTR_INIT    = 2'b10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        fetch_valid,
  output logic        fetch_pred_taken,
  output logic        init_busy,
  input  logic        exec_ld_pc,
  input  logic [31:0] exec_br_pc,
  input  logic        exec_upd,
  input  logic [31:0] exec_upd_pc,
  input  logic [31:0] exec_upd_target,
  input  logic        exec_upd_taken,
  input  logic        decode_flush,
  input  logic        decode_stall,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_stb,
  input  logic [31:0] mem_req_data,
  input  logic        mem_req_valid,
  output logic        dbg_state
);

  localparam int              IDXW     = $clog2(BTB_ENTRIES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BTB_ENTRIES - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] sweep_q;
  logic [31:0]     r_pc;
  logic [31:0]     next_pc;
  logic            pred_taken;
  logic [31:0]     pred_target;

  assign dbg_state = state_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) sweep_q <= sweep_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_busy   = 1'b0;
    mem_req_stb = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        if (sweep_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: mem_req_stb = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  btb_bimodal #(
    .BTB_ENTRIES (BTB_ENTRIES),
    .CTR_INIT    (CTR_INIT)
  ) u_btb (
    .i_clk       (i_clk),
    .clr_en      (state_q == ST_INIT),
    .clr_idx     (sweep_q),
    .lookup_pc   (r_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (exec_upd && (state_q == ST_RUN)),
    .upd_pc      (exec_upd_pc),
    .upd_target  (exec_upd_target),
    .upd_taken   (exec_upd_taken)
  );

  assign next_pc      = pred_taken ? pred_target : r_pc + 32'd4;
  assign mem_req_addr = r_pc;

  // Handshake: mem_req_stb with mem_req_addr is the request; mem_req_valid high in the
  // same cycle returns mem_req_data for that address and completes it. The address holds
  // until a cycle with mem_req_valid high and no flush/stall; a flush abandons it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc         <= '0;
      fetch_inst       <= '0;
      fetch_valid      <= 1'b0;
      fetch_pred_taken <= 1'b0;
      r_pc             <= RESET_PC;
    end else if (state_q == ST_RUN) begin
      if (decode_flush) begin
        fetch_valid <= 1'b0;
        fetch_inst  <= '0;
        r_pc        <= exec_ld_pc ? exec_br_pc : RESET_PC;
      end else if (!decode_stall) begin
        if (mem_req_valid) begin
          fetch_inst       <= mem_req_data;
          fetch_pc         <= r_pc;
          fetch_valid      <= 1'b1;
          fetch_pred_taken <= pred_taken;
          r_pc             <= next_pc;
        end else begin
          fetch_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit_bp.sv
// Self-checking bench for fetch_unit_bp with a small table-based reference model.
module tb_fetch_unit_bp;

  localparam int N    = 16;
  localparam int IDXW = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] fetch_pc, fetch_inst;
  logic        fetch_valid, fetch_pred_taken, init_busy;
  logic        exec_ld_pc;
  logic [31:0] exec_br_pc;
  logic        exec_upd;
  logic [31:0] exec_upd_pc, exec_upd_target;
  logic        exec_upd_taken;
  logic        decode_flush, decode_stall;
  logic [31:0] mem_req_addr;
  logic        mem_req_stb;
  logic [31:0] mem_req_data;
  logic        mem_req_valid;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_run;
  int          m_sweep;
  logic [31:0] m_pc, m_fpc, m_finst;
  bit          m_fvalid, m_fpred;
  bit          m_v[N];
  logic [31:0] m_tag[N], m_tgt[N];
  int          m_ctr[N];

  fetch_unit_bp #(.BTB_ENTRIES(N), .RESET_PC(32'h100), .CTR_INIT(2'b10)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .fetch_pc(fetch_pc), .fetch_inst(fetch_inst), .fetch_valid(fetch_valid),
    .fetch_pred_taken(fetch_pred_taken), .init_busy(init_busy),
    .exec_ld_pc(exec_ld_pc), .exec_br_pc(exec_br_pc),
    .exec_upd(exec_upd), .exec_upd_pc(exec_upd_pc), .exec_upd_target(exec_upd_target),
    .exec_upd_taken(exec_upd_taken),
    .decode_flush(decode_flush), .decode_stall(decode_stall),
    .mem_req_addr(mem_req_addr), .mem_req_stb(mem_req_stb),
    .mem_req_data(mem_req_data), .mem_req_valid(mem_req_valid),
    .dbg_state(dbg_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_run = 0; m_sweep = 0; m_pc = 32'h100;
    m_fpc = 0; m_finst = 0; m_fvalid = 0; m_fpred = 0;
  endtask

  task automatic model_step();
    int li, ui;
    bit pred, uhit;
    logic [31:0] nxt;
    if (i_reset) begin model_reset(); return; end
    if (!m_run) begin
      m_v[m_sweep] = 0;
      if (m_sweep == N - 1) m_run = 1; else m_sweep++;
      return;
    end
    li   = int'((m_pc >> 2) % N);
    pred = m_v[li] && (m_tag[li] == (m_pc >> (IDXW + 2))) && (m_ctr[li] >= 2);
    nxt  = pred ? m_tgt[li] : m_pc + 32'd4;
    if (decode_flush) begin
      m_fvalid = 0; m_finst = 0;
      m_pc = exec_ld_pc ? exec_br_pc : 32'h100;
    end else if (!decode_stall) begin
      if (mem_req_valid) begin
        m_finst = mem_req_data; m_fpc = m_pc; m_fvalid = 1; m_fpred = pred; m_pc = nxt;
      end else begin
        m_fvalid = 0;
      end
    end
    if (exec_upd) begin
      ui   = int'((exec_upd_pc >> 2) % N);
      uhit = m_v[ui] && (m_tag[ui] == (exec_upd_pc >> (IDXW + 2)));
      if (exec_upd_taken) begin
        if (uhit) begin
          m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_tgt[ui] = exec_upd_target;
        end else begin
          m_v[ui] = 1; m_tag[ui] = exec_upd_pc >> (IDXW + 2);
          m_tgt[ui] = exec_upd_target; m_ctr[ui] = 2;
        end
      end else if (uhit) begin
        m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      end
    end
  endtask

  task automatic idle_inputs();
    exec_ld_pc = 0; exec_br_pc = 0; exec_upd = 0; exec_upd_pc = 0;
    exec_upd_target = 0; exec_upd_taken = 0; decode_flush = 0; decode_stall = 0;
    mem_req_valid = 0;
  endtask

  // One clock: inputs are stable from the previous falling edge; outputs sampled at the next one.
  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    mem_req_data = $urandom;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    mem_req_data = $urandom;
    i_reset = 1;
    model_reset();
    tick();
    checks++; if (fetch_pc !== 32'h0 || fetch_inst !== 32'h0) begin errors++;
      $display("FAIL reset_fetch_regs: pc=%h inst=%h expected 0/0", fetch_pc, fetch_inst); end
    checks++; if (fetch_valid !== 1'b0 || fetch_pred_taken !== 1'b0) begin errors++;
      $display("FAIL reset_flags: valid=%b pred=%b expected 0/0", fetch_valid, fetch_pred_taken); end
    checks++; if (init_busy !== 1'b1 || mem_req_stb !== 1'b0) begin errors++;
      $display("FAIL reset_busy: busy=%b stb=%b expected 1/0", init_busy, mem_req_stb); end
    i_reset = 0;
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin tick(); n++; end
    checks++; if (n != N) begin errors++;
      $display("FAIL init_length: busy cycles=%0d expected %0d", n, N); end
    checks++; if (mem_req_stb !== 1'b1 || mem_req_addr !== 32'h100) begin errors++;
      $display("FAIL first_addr: stb=%b addr=%h expected 1/00000100", mem_req_stb, mem_req_addr); end
    mem_req_valid = 1;
    tick();
    checks++; if (mem_req_addr !== 32'h104 || fetch_pc !== 32'h100 || fetch_valid !== 1'b1) begin errors++;
      $display("FAIL seq_104: addr=%h fpc=%h valid=%b expected 104/100/1", mem_req_addr, fetch_pc, fetch_valid); end
    tick();
    checks++; if (mem_req_addr !== 32'h108 || fetch_pc !== 32'h104) begin errors++;
      $display("FAIL seq_108: addr=%h fpc=%h expected 108/104", mem_req_addr, fetch_pc); end
    mem_req_valid = 0;
    tick();
  endtask

  task automatic test_predict_taken();
    exec_upd = 1; exec_upd_pc = 32'h108; exec_upd_target = 32'h200; exec_upd_taken = 1;
    tick(); tick();
    exec_upd = 0;
    decode_flush = 1; exec_ld_pc = 1; exec_br_pc = 32'h108;
    tick();
    decode_flush = 0; exec_ld_pc = 0;
    checks++; if (fetch_valid !== 1'b0 || mem_req_addr !== 32'h108) begin errors++;
      $display("FAIL redirect_108: valid=%b addr=%h expected 0/108", fetch_valid, mem_req_addr); end
    mem_req_valid = 1;
    tick();
    mem_req_valid = 0;
    checks++; if (fetch_pc !== 32'h108 || fetch_pred_taken !== 1'b1 || mem_req_addr !== 32'h200) begin errors++;
      $display("FAIL predict_taken: fpc=%h pred=%b addr=%h expected 108/1/200", fetch_pc, fetch_pred_taken, mem_req_addr); end
  endtask

  task automatic test_predict_not_taken();
    exec_upd = 1; exec_upd_pc = 32'h108; exec_upd_target = 32'h200; exec_upd_taken = 0;
    tick(); tick();
    exec_upd = 0;
    decode_flush = 1; exec_ld_pc = 1; exec_br_pc = 32'h108;
    tick();
    decode_flush = 0; exec_ld_pc = 0;
    mem_req_valid = 1;
    tick();
    checks++; if (fetch_pc !== 32'h108 || fetch_pred_taken !== 1'b0 || mem_req_addr !== 32'h10C) begin errors++;
      $display("FAIL predict_not_taken: fpc=%h pred=%b addr=%h expected 108/0/10c", fetch_pc, fetch_pred_taken, mem_req_addr); end
  endtask

  task automatic test_flush_over_stall();
    tick();
    checks++; if (fetch_valid !== 1'b1) begin errors++;
      $display("FAIL pre_flush_valid: valid=%b expected 1", fetch_valid); end
    decode_flush = 1; decode_stall = 1; exec_ld_pc = 1; exec_br_pc = 32'h300;
    tick();
    decode_flush = 0; decode_stall = 0; exec_ld_pc = 0; mem_req_valid = 0;
    checks++; if (fetch_valid !== 1'b0 || fetch_inst !== 32'h0 || mem_req_addr !== 32'h300) begin errors++;
      $display("FAIL flush_stall: valid=%b inst=%h addr=%h expected 0/0/300", fetch_valid, fetch_inst, mem_req_addr); end
  endtask

  task automatic test_mem_wait();
    logic [31:0] exp_data;
    mem_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_req_addr !== 32'h300 || fetch_valid !== 1'b0) begin errors++;
        $display("FAIL mem_wait_%0d: addr=%h valid=%b expected 300/0", i, mem_req_addr, fetch_valid); end
    end
    mem_req_valid = 1;
    exp_data = mem_req_data;
    tick();
    mem_req_valid = 0;
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h300 || fetch_inst !== exp_data) begin errors++;
      $display("FAIL mem_accept: valid=%b pc=%h inst=%h expected 1/300/%h", fetch_valid, fetch_pc, fetch_inst, exp_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      decode_flush    = ($urandom_range(0, 15) == 0);
      decode_stall    = ($urandom_range(0, 7) == 0);
      exec_ld_pc      = $urandom_range(0, 1);
      exec_br_pc      = 32'h100 + 4 * $urandom_range(0, 31);
      mem_req_valid   = ($urandom_range(0, 3) != 0);
      exec_upd        = ($urandom_range(0, 2) == 0);
      exec_upd_pc     = 32'h100 + 4 * $urandom_range(0, 31);
      exec_upd_target = 32'h100 + 4 * $urandom_range(0, 31);
      exec_upd_taken  = $urandom_range(0, 1);
      tick();
      checks++; if (fetch_pc !== m_fpc) begin errors++;
        $display("FAIL rnd_fetch_pc c=%0d: got %h expected %h", c, fetch_pc, m_fpc); end
      checks++; if (fetch_inst !== m_finst) begin errors++;
        $display("FAIL rnd_fetch_inst c=%0d: got %h expected %h", c, fetch_inst, m_finst); end
      checks++; if (fetch_valid !== m_fvalid) begin errors++;
        $display("FAIL rnd_fetch_valid c=%0d: got %b expected %b", c, fetch_valid, m_fvalid); end
      checks++; if (fetch_pred_taken !== m_fpred) begin errors++;
        $display("FAIL rnd_pred c=%0d: got %b expected %b", c, fetch_pred_taken, m_fpred); end
      checks++; if (mem_req_addr !== m_pc) begin errors++;
        $display("FAIL rnd_addr c=%0d: got %h expected %h", c, mem_req_addr, m_pc); end
      checks++; if (mem_req_stb !== 1'b1 || init_busy !== 1'b0) begin errors++;
        $display("FAIL rnd_run c=%0d: stb=%b busy=%b expected 1/0", c, mem_req_stb, init_busy); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    i_reset = 1; model_reset();
    tick();
    i_reset = 0;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (init_busy !== 1'b1) begin errors++;
      $display("FAIL mid_sweep_busy: got %b expected 1", init_busy); end
    i_reset = 1; model_reset();
    #1;
    checks++; if (init_busy !== 1'b1 || fetch_valid !== 1'b0 || mem_req_stb !== 1'b0) begin errors++;
      $display("FAIL mid_reset_async: busy=%b valid=%b stb=%b expected 1/0/0", init_busy, fetch_valid, mem_req_stb); end
    tick();
    i_reset = 0;
    exec_upd = 1; exec_upd_pc = 32'h100; exec_upd_target = 32'h400; exec_upd_taken = 1;
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin tick(); n++; end
    exec_upd = 0;
    checks++; if (n != N) begin errors++;
      $display("FAIL restart_length: busy cycles=%0d expected %0d", n, N); end
    mem_req_valid = 1;
    tick();
    mem_req_valid = 0;
    checks++; if (fetch_pc !== 32'h100 || fetch_pred_taken !== 1'b0 || mem_req_addr !== 32'h104) begin errors++;
      $display("FAIL init_upd_ignored: fpc=%h pred=%b addr=%h expected 100/0/104", fetch_pc, fetch_pred_taken, mem_req_addr); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0; end
    test_reset();
    test_predict_taken();
    test_predict_not_taken();
    test_flush_over_stall();
    test_mem_wait();
    test_random();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit_bp.md
FETCH_UNIT_BP -- requirements
Module: fetch_unit_bp

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 256, BTB entry count (power of two, 4..1024).
REQ-002 SHALL have parameter RESET_PC, default 32'h100, first fetch address after init and after a non-redirect flush.
REQ-003 SHALL have parameter CTR_INIT, default 2'b10, counter value written on a new taken allocation.
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_reset  in  1  reset, asynchronous, active-high.
REQ-006 fetch_pc  out  32  PC of the instruction in fetch_inst.
REQ-007 fetch_inst  out  32  fetched instruction word.
REQ-008 fetch_valid  out  1  fetch_pc and fetch_inst hold a real instruction.
REQ-009 fetch_pred_taken  out  1  next PC after fetch_pc came from a BTB target.
REQ-010 init_busy  out  1  BTB clear sweep in progress.
REQ-011 exec_ld_pc  in  1  redirect request; exec_br_pc is the new PC.
REQ-012 exec_br_pc  in  32  redirect target.
REQ-013 exec_upd  in  1  resolved branch update strobe.
REQ-014 exec_upd_pc / exec_upd_target  in  32 each  resolved branch PC and its target.
REQ-015 exec_upd_taken  in  1  resolved direction.
REQ-016 decode_flush / decode_stall  in  1 each  squash fetch / hold fetch.
REQ-017 mem_req_addr  out  32  fetch address; mem_req_stb  out  1  request.
REQ-018 mem_req_data  in  32  read data; mem_req_valid  in  1  data valid this cycle for mem_req_addr.

Function
REQ-019 SHALL use a two-state FSM, INIT -> RUN, entered in INIT on reset.
REQ-020 INIT SHALL clear one valid bit per cycle, index 0..BTB_ENTRIES-1, then go to RUN; init_busy=1 and mem_req_stb=0 throughout INIT.
REQ-021 In RUN: mem_req_stb=1 and mem_req_addr=r_pc, held stable until accepted.
REQ-022 Lookup: index=pc[IDXW+1:2], tag=pc[31:IDXW+2], IDXW=log2(BTB_ENTRIES); hit = valid & tag match.
REQ-023 next_pc = stored target if hit and counter[1]=1, else r_pc+4 (mod 2^32); pred bit registered with the instruction.
REQ-024 Accept: RUN, !decode_flush, !decode_stall, mem_req_valid -> fetch_inst<=mem_req_data, fetch_pc<=r_pc, fetch_valid<=1, r_pc<=next_pc.
REQ-025 RUN, no flush/stall, !mem_req_valid -> fetch_valid<=0, r_pc held.
REQ-026 decode_stall without flush -> all fetch outputs and r_pc held.
REQ-027 decode_flush -> fetch_valid<=0, fetch_inst<=0; r_pc<=exec_br_pc if exec_ld_pc, else RESET_PC; flush takes priority over stall and memory.
REQ-028 Update (exec_upd, RUN only), taken: tag hit -> counter saturating +1, target rewritten; miss -> allocate valid, tag, target, counter=CTR_INIT.
REQ-029 Update, not taken: tag hit -> counter saturating -1 (floor 0); miss -> no change.
REQ-030 Same-cycle lookup and update on one index -> lookup uses pre-update contents.
REQ-031 exec_upd during INIT SHALL be ignored.

Reset
REQ-032 On i_reset: fetch_pc=0, fetch_inst=0, fetch_valid=0, fetch_pred_taken=0, r_pc=RESET_PC, init_busy=1, sweep counter=0, FSM=INIT.
REQ-033 Reset asserted mid-sweep or mid-fetch SHALL restart the sweep from index 0.

Structure
REQ-034 Shared package fetch_pkg SHALL hold the 2-bit ctr_t typedef, the FSM state enum, and the saturating inc/dec functions.
REQ-035 The array with lookup and update logic SHALL be the sub-module btb_bimodal.

Verification
REQ-036 Reset, BTB_ENTRIES=16 -> init_busy high 16 cycles, first mem_req_addr=32'h100, then 0x104, 0x108 with mem_req_valid tied 1.
REQ-037 Two taken updates at pc 0x108 -> 0x200 -> next fetch of 0x108 gives fetch_pred_taken=1 and next address 0x200.
REQ-038 Then two not-taken updates at 0x108 -> counter 2'b01, fetch after 0x108 is 0x10C.
REQ-039 decode_flush with exec_ld_pc and exec_br_pc=0x300 while decode_stall=1 -> fetch_valid=0, next mem_req_addr=0x300.
REQ-040 mem_req_valid low 3 cycles -> mem_req_addr stable, fetch_valid=0 for those cycles, then one accept.
REQ-041 i_reset pulsed at sweep index 7 -> sweep restarts at 0, init_busy high a full BTB_ENTRIES cycles after release.
